// File: rtl/fsm_detector_pkg.sv
// ---------------------------------------------------------------------------
// fsm_detector_pkg
//
// Shared definitions for the "0110" serial sequence detector.
// Contents:
//   state_t  - 3-bit state register type
//   IDLE, S0, S01, S011, DET - state codes, where each code records the
//              longest prefix of the pattern matched so far
//   PATTERN  - the detected bit pattern, oldest bit in the MSB
// ---------------------------------------------------------------------------
package fsm_detector_pkg;

    typedef logic [2:0] state_t;

    // Codes 3'd5 to 3'd7 are unused and recover to IDLE on the next clock.
    localparam state_t IDLE = 3'd0;
    localparam state_t S0   = 3'd1;
    localparam state_t S01  = 3'd2;
    localparam state_t S011 = 3'd3;
    localparam state_t DET  = 3'd4;

    localparam logic [3:0] PATTERN = 4'b0110;

endpackage

// File: rtl/fsm_detector.sv
// ---------------------------------------------------------------------------
// fsm_detector
//
// Moore detector for the overlapping serial pattern "0110". One input bit
// is sampled on every rising clock edge. tick is high for exactly the cycle
// the FSM sits in DET, i.e. the cycle after the final "0" is sampled.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset, forces IDLE
//   seq       in   serial data bit. The name "sequence" is a reserved
//                  SystemVerilog keyword, so the input is called seq.
//   tick      out  detection flag, high while state_reg == DET
//   state_reg out  the state register itself, for debug/observation
// ---------------------------------------------------------------------------
module fsm_detector
    import fsm_detector_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       seq,
    output logic       tick,
    output logic [2:0] state_reg
);

    state_t next_state;

    // State register. Reset is sampled on the clock edge and takes priority
    // over the data bit, so a reset in the middle of a pattern throws away
    // any partial match.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= next_state;
        end
    end

    // Next-state logic. Each state holds the longest pattern prefix matched
    // so far. On a failed bit we fall back to the longest prefix that is
    // still a suffix of the bits seen: a stray "0" always restarts at S0.
    // From DET the trailing "0" of the match is reused as the leading "0"
    // of the next one, which is what lets matches overlap every 3 bits.
    // Unused codes recover to IDLE regardless of the input.
    always_comb begin
        next_state = IDLE;
        case (state_reg)
            IDLE:    next_state = seq ? IDLE : S0;
            S0:      next_state = seq ? S01  : S0;
            S01:     next_state = seq ? S011 : S0;
            S011:    next_state = seq ? IDLE : DET;
            DET:     next_state = seq ? S01  : S0;
            default: next_state = IDLE;
        endcase
    end

    // Output decode. Moore output that depends only on the state register,
    // so it is low in IDLE, the prefix states and the unused codes.
    always_comb begin
        tick = 1'b0;
        if (state_reg == DET) begin
            tick = 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_detector.sv
// ---------------------------------------------------------------------------
// tb_fsm_detector
//
// Testbench for fsm_detector. A table of {reset, bit, expected state,
// expected tick} records is played one record per clock. A hand-written
// sequence then streams back-to-back patterns and checks the tick spacing.
// ---------------------------------------------------------------------------
module tb_fsm_detector;
    import fsm_detector_pkg::*;

    typedef struct {
        logic       rst_n;
        logic       bit_in;
        logic [2:0] exp_state;
        logic       exp_tick;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       seq;
    logic       tick;
    logic [2:0] state_reg;

    int checks;
    int errors;

    vec_t vecs[$];

    fsm_detector dut (
        .clk       (clk),
        .reset     (reset),
        .seq       (seq),
        .tick      (tick),
        .state_reg (state_reg)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the DUT outputs against the expected values for one cycle.
    task automatic checkOutput(input string name, input logic [2:0] exp_state,
                               input logic exp_tick);
        checks++;
        if (state_reg !== exp_state) begin
            errors++;
            $display("[TB] FAIL %s state_reg got %0d expected %0d", name, state_reg, exp_state);
        end
        checks++;
        if (tick !== exp_tick) begin
            errors++;
            $display("[TB] FAIL %s tick got %0b expected %0b", name, tick, exp_tick);
        end
    endtask

    // Drive inputs away from the active edge, let one rising edge pass and
    // settle just after it so the sampled outputs belong to the new state.
    task automatic applyStimulus(input logic rst_n, input logic bit_in);
        @(negedge clk);
        reset = rst_n;
        seq   = bit_in;
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(input logic r, input logic b,
                                   input logic [2:0] s, input logic t);
        vec_t v;
        v.rst_n     = r;
        v.bit_in    = b;
        v.exp_state = s;
        v.exp_tick  = t;
        vecs.push_back(v);
    endfunction

    initial begin
        int tick_count;
        int first_tick;
        int second_tick;
        logic [6:0] stream;
        logic [3:0] pat;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        seq    = 1'b0;

        // Reset held for two cycles while the data bit toggles.
        addVec(0, 0, 3'd0, 0);
        addVec(0, 1, 3'd0, 0);
        // Release with a 0, then the basic stream 0,0,1,0,0,0,1,1,0.
        addVec(1, 0, 3'd1, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 1, 3'd2, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 1, 3'd2, 0);
        addVec(1, 1, 3'd3, 0);
        addVec(1, 0, 3'd4, 1);
        // Overlap: 0,1,1,0,1,1,0 then a 0 to leave DET through S0.
        addVec(0, 0, 3'd0, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 1, 3'd2, 0);
        addVec(1, 1, 3'd3, 0);
        addVec(1, 0, 3'd4, 1);
        addVec(1, 1, 3'd2, 0);
        addVec(1, 1, 3'd3, 0);
        addVec(1, 0, 3'd4, 1);
        addVec(1, 0, 3'd1, 0);
        // Near misses: 0,1,1,1,0,1,0.
        addVec(0, 1, 3'd0, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 1, 3'd2, 0);
        addVec(1, 1, 3'd3, 0);
        addVec(1, 1, 3'd0, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 1, 3'd2, 0);
        addVec(1, 0, 3'd1, 0);
        // Mid-pattern reset: 0,1,1 then reset, then 0.
        addVec(0, 0, 3'd0, 0);
        addVec(1, 0, 3'd1, 0);
        addVec(1, 1, 3'd2, 0);
        addVec(1, 1, 3'd3, 0);
        addVec(0, 0, 3'd0, 0);
        addVec(1, 0, 3'd1, 0);
        // All ones from a clean start, then all zeros.
        addVec(0, 0, 3'd0, 0);
        for (int i = 0; i < 8; i++) addVec(1, 1, 3'd0, 0);
        for (int i = 0; i < 8; i++) addVec(1, 0, 3'd1, 0);

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].bit_in);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_tick);
        end

        // Back-to-back matches built from PATTERN: "0110" followed by the
        // last three bits again gives "0110110", ticks after bits 4 and 7.
        pat    = PATTERN;
        stream = {pat, pat[2:0]};
        applyStimulus(0, 0);
        checkOutput("b2b_reset", 3'd0, 0);
        tick_count  = 0;
        first_tick  = -1;
        second_tick = -1;
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(1, stream[i]);
            if (tick === 1'b1) begin
                tick_count++;
                if (first_tick < 0) first_tick = 7 - i;
                else if (second_tick < 0) second_tick = 7 - i;
            end
        end
        checks++;
        if (tick_count != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d expected 2", tick_count);
        end
        checks++;
        if (first_tick != 4) begin
            errors++;
            $display("[TB] FAIL b2b_first got bit %0d expected bit 4", first_tick);
        end
        checks++;
        if (second_tick != 7) begin
            errors++;
            $display("[TB] FAIL b2b_second got bit %0d expected bit 7", second_tick);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
